// File: rtl/kyber_pkg.sv
// Shared constants and FSM encoding for the polynomial byte-stream unpackers.
package kyber_pkg;
  localparam int Q          = 3329;
  localparam int NUM_COEFFS = 256;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Bytes per polynomial: 256 coefficients of ell bits each, packed tightly.
  function automatic int byte_count(input int ell);
    return 32 * ell;
  endfunction
endpackage

// File: rtl/poly_byte_unpack.sv
// Unpacks an LSB-first byte stream into NUM_COEFFS coefficients of ELL bits.
// The accumulator is inline, and coeff comes straight from the buffer's low bits.
module poly_byte_unpack #(
  parameter int ELL        = 12,
  parameter int NUM_COEFFS = kyber_pkg::NUM_COEFFS,
  parameter int Q          = kyber_pkg::Q
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [7:0]     in_data,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [ELL-1:0] coeff,
  output logic           coeff_valid,
  input  logic           coeff_ready,
  output logic [7:0]     coeff_idx,
  output logic           done,
  output logic           err_range
);
  import kyber_pkg::*;

  localparam int BYTE_COUNT = byte_count(ELL);
  localparam int BUFW       = ELL + 7;
  localparam int BCW        = $clog2(ELL + 8);
  localparam int BTW        = $clog2(BYTE_COUNT + 1);

  state_e          state;
  logic [BUFW-1:0] bit_buf;
  logic [BCW-1:0]  bit_count;
  logic [BTW-1:0]  bytes_taken;
  logic [7:0]      idx_q;
  logic            err_q;

  logic accept, pop, last, over_q;

  assign in_ready    = (state == RUN) && (bit_count < BCW'(ELL)) &&
                       (bytes_taken < BTW'(BYTE_COUNT));
  assign coeff_valid = (state == RUN) && (bit_count >= BCW'(ELL));
  assign accept      = in_valid && in_ready;
  assign pop         = coeff_valid && coeff_ready;
  assign last        = (idx_q == 8'(NUM_COEFFS - 1));

  assign coeff     = bit_buf[ELL-1:0];
  assign coeff_idx = idx_q;
  assign done      = (state == DONE);
  // Range check only has meaning for full 12-bit coefficients.
  assign over_q    = (ELL == 12) && ({{(32-ELL){1'b0}}, coeff} >= Q[31:0]);
  assign err_range = (ELL == 12) ? err_q : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_buf     <= '0;
      bit_count   <= '0;
      bytes_taken <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state       <= RUN;
          bit_buf     <= '0;
          bit_count   <= '0;
          bytes_taken <= '0;
          idx_q       <= '0;
          err_q       <= 1'b0;
        end
        RUN: begin
          // accept needs bit_count < ELL, pop needs >= ELL: never both.
          if (accept) begin
            bit_buf     <= bit_buf | (BUFW'(in_data) << bit_count);
            bit_count   <= bit_count + BCW'(8);
            bytes_taken <= bytes_taken + 1'b1;
          end else if (pop) begin
            bit_buf   <= bit_buf >> ELL;
            bit_count <= bit_count - BCW'(ELL);
            idx_q     <= last ? 8'd0 : idx_q + 8'd1;
            if (over_q) err_q <= 1'b1;
            if (last) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_byte_unpack.sv
// Bench for poly_byte_unpack: bit-stream model scoreboard plus directed literal checks.
module tb_poly_byte_unpack;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_ready, coeff_valid, coeff_ready, done, err_range;
  logic [7:0]  in_data, coeff_idx;
  logic [11:0] coeff;

  logic        start1, in_valid1, in_ready1, cv1, cr1, done1, err1;
  logic [7:0]  in_data1, idx1;
  logic [0:0]  coeff1;

  always #5 clk = ~clk;

  poly_byte_unpack #(.ELL(12)) u12 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .coeff(coeff), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
    .coeff_idx(coeff_idx), .done(done), .err_range(err_range));

  poly_byte_unpack #(.ELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .coeff(coeff1), .coeff_valid(cv1), .coeff_ready(cr1),
    .coeff_idx(idx1), .done(done1), .err_range(err1));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Model: the source stream, and coefficient i is stream bits i*12 .. i*12+11.
  logic [7:0] src [384];
  int  p, n_pop, n_acc;
  bit  err_m, chk_en, drv_en, gaps, stall, hold_pend;
  logic [11:0] prev_coeff;
  logic [7:0]  prev_idx;
  int  got_c [4];
  bit  got_e [4];

  function automatic int exp_coeff(input int i);
    int v, b;
    v = 0;
    for (int j = 0; j < 12; j++) begin
      b = i * 12 + j;
      if (src[b / 8][b % 8]) v = v | (1 << j);
    end
    return v;
  endfunction

  // Byte driver: presents src[p], advancing only on a completed handshake.
  initial begin
    logic hs;
    in_valid = 1'b0; in_data = 8'h00; p = 0;
    forever begin
      @(negedge clk);
      hs = in_valid && in_ready && rst_n;
      @(posedge clk); #1;
      if (hs) p++;
      in_valid = drv_en && (gaps ? ($urandom % 4 != 0) : 1'b1);
      in_data  = src[(p < 384) ? p : 383];
    end
  end

  initial begin
    coeff_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      coeff_ready = stall ? ($urandom % 3 != 0) : 1'b1;
    end
  end

  // Scoreboard: every pop against the model, every stalled cycle against the previous one.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (hold_pend) begin
        check("hold_valid", coeff_valid, 1);
        check("hold_coeff", coeff, prev_coeff);
        check("hold_idx", coeff_idx, prev_idx);
      end
      if (in_valid && in_ready) n_acc++;
      if (coeff_valid && coeff_ready) begin
        int e;
        e = exp_coeff(n_pop % 256);
        check("coeff", coeff, e);
        check("coeff_idx", coeff_idx, n_pop % 256);
        check("err_range", err_range, err_m);
        if (n_pop < 4) begin got_c[n_pop] = coeff; got_e[n_pop] = err_range; end
        if (e >= 3329) err_m = 1'b1;
        n_pop++;
      end
      hold_pend  = coeff_valid && !coeff_ready;
      prev_coeff = coeff;
      prev_idx   = coeff_idx;
    end else hold_pend = 1'b0;
  end

  task automatic clear_model();
    n_pop = 0; n_acc = 0; err_m = 1'b0; hold_pend = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_coeff_valid"}, coeff_valid, 0);
    check({tag, "_coeff"}, coeff, 0);
    check({tag, "_coeff_idx"}, coeff_idx, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err_range"}, err_range, 0);
  endtask

  int cyc;
  int a1;
  bit seen1;
  logic [0:0] got1 [8];
  int exp1 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

  initial begin
    rst_n = 1'b0; start = 1'b0; chk_en = 0; drv_en = 0; gaps = 0; stall = 0;
    start1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'hA5; cr1 = 1'b1;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_u1_in_ready", in_ready1, 0);
    rst_n = 1'b1;

    // Run 1: free flowing, known leading bytes, done timing.
    src[0] = 8'h49; src[1] = 8'h8B; src[2] = 8'h0B;
    src[3] = 8'hFF; src[4] = 8'hFE; src[5] = 8'hCE;
    for (int i = 6; i < 384; i++) src[i] = 8'($urandom);
    clear_model(); p = 0; drv_en = 1; chk_en = 1;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 3000) begin @(posedge clk); cyc++; #1; end
    check("done_cycle", cyc, 640);
    check("run1_pops", n_pop, 256);
    check("run1_bytes", n_acc, 384);
    check("lit_coeff0", got_c[0], 2889);
    check("lit_coeff1", got_c[1], 184);
    check("lit_coeff2", got_c[2], 3839);
    check("lit_coeff3", got_c[3], 3311);
    check("lit_err_before", got_e[1], 0);
    check("lit_err_after", got_e[3], 1);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("in_ready_after", in_ready, 0);
    repeat (5) @(posedge clk); #1;
    check("in_ready_idle", in_ready, 0);
    check("err_sticky", err_range, 1);

    // Run 2: random input gaps and consumer stalls, stray start mid-run.
    for (int i = 0; i < 384; i++) src[i] = 8'($urandom);
    clear_model(); p = 0; gaps = 1; stall = 1;
    pulse_start();
    check("err_cleared_on_start", err_range, 0);
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(posedge clk); cyc++; #1;
      start = (cyc == 50);
    end
    start = 1'b0;
    check("run2_done_seen", done, 1);
    check("run2_pops", n_pop, 256);
    check("run2_bytes", n_acc, 384);
    check("run2_err_final", err_range, err_m);
    gaps = 0; stall = 0;

    // Run 3: reset after 100 bytes, then a clean restart from byte 0.
    for (int i = 0; i < 384; i++) src[i] = 8'($urandom) | 8'hF0;
    clear_model(); p = 0;
    pulse_start();
    cyc = 0;
    while (n_acc < 100 && cyc < 1000) begin @(posedge clk); cyc++; #1; end
    check("run3_reached_100", n_acc >= 100, 1);
    @(negedge clk);
    chk_en = 0; drv_en = 0; rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk); @(negedge clk);
    p = 0; clear_model();
    rst_n = 1'b1; drv_en = 1; chk_en = 1;
    pulse_start();
    cyc = 0;
    while (!done && cyc < 3000) begin @(posedge clk); cyc++; #1; end
    check("run3_done_cycle", cyc, 640);
    check("run3_pops", n_pop, 256);
    check("run3_bytes", n_acc, 384);
    chk_en = 0; drv_en = 0;

    // ELL=1 instance: byte A5 then zeros.
    in_valid1 = 1'b1; a1 = 0; seen1 = 0;
    for (int k = 0; k < 8; k++) got1[k] = 1'bx;
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int c = 0; c < 400 && !seen1; c++) begin
      @(negedge clk);
      if (in_valid1 && in_ready1) a1++;
      if (cv1 && idx1 < 8) got1[idx1[2:0]] = coeff1;
      if (done1) seen1 = 1;
      @(posedge clk); #1;
      in_data1 = (a1 == 0) ? 8'hA5 : 8'h00;
    end
    for (int k = 0; k < 8; k++) check($sformatf("ell1_coeff%0d", k), got1[k], exp1[k]);
    check("ell1_done_seen", seen1, 1);
    check("ell1_bytes", a1, 32);
    check("ell1_err_tied", err1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/poly_byte_unpack.md
POLY_BYTE_UNPACK -- requirements
Module: poly_byte_unpack

Interface
REQ-001 SHALL have parameter ELL, default 12, meaning the coefficient bit width; legal values are 1, 4, 5, 10, 11 and 12.
REQ-002 SHALL have parameter NUM_COEFFS, default 256, meaning the number of coefficients per polynomial.
REQ-003 SHALL have parameter Q, default 3329, meaning the modulus used for the range check.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle pulse that begins unpacking one polynomial.
REQ-007 SHALL have port in_data  input  8  packed byte stream, least-significant-bit first.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-010 SHALL have port coeff  output  ELL  current unpacked coefficient.
REQ-011 SHALL have port coeff_valid  output  1  coeff is valid.
REQ-012 SHALL have port coeff_ready  input  1  consumer accepts coeff.
REQ-013 SHALL have port coeff_idx  output  8  index of the current coeff, from 0 to NUM_COEFFS-1.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last coefficient is accepted.
REQ-015 SHALL have port err_range  output  1  sticky flag: some coefficient was >= Q (ELL=12 only; tied to 0 otherwise).

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE. IDLE goes to RUN on start. RUN goes to DONE when the last coefficient handshake completes. DONE goes to IDLE unconditionally after one cycle.
REQ-017 SHALL consume exactly BYTE_COUNT = 32*ELL bytes and produce exactly NUM_COEFFS coefficients per start.
REQ-018 SHALL pack bits so that bit j of coefficient i equals stream bit i*ELL+j, where byte k bit b is stream bit 8k+b.
REQ-019 SHALL hold a bit buffer of ELL+7 bits and a bit count; an accepted byte is OR-ed in at position bit_count, and a popped coefficient is taken from the low ELL bits, with the buffer then shifted right by ELL.
REQ-020 SHALL drive in_ready = (state==RUN) && (bit_count < ELL) && (bytes_taken < BYTE_COUNT); a byte is accepted on in_valid && in_ready.
REQ-021 SHALL drive coeff_valid = (state==RUN) && (bit_count >= ELL); a coefficient is popped on coeff_valid && coeff_ready. Because the two conditions are exclusive, accept and pop never occur in the same cycle.
REQ-022 SHALL hold coeff, coeff_idx and coeff_valid stable while coeff_valid && !coeff_ready.
REQ-023 SHALL have coeff present combinationally the same cycle bit_count reaches ELL, i.e. zero cycles of latency from register to output.
REQ-024 SHALL give, with no stalls and ELL=12, throughput of 3 bytes to 2 coefficients every 5 cycles.
REQ-025 SHALL have bit_count equal 0 when entering DONE, and SHALL assert done in the DONE cycle only.
REQ-026 SHALL ignore start while in RUN or DONE.
REQ-027 SHALL clear err_range on an accepted start, set it on any popped coefficient >= Q, and hold it until the next start.
REQ-028 SHALL keep in_ready and coeff_valid low in IDLE and DONE.

Reset
REQ-029 SHALL, on rst_n low, immediately (asynchronously) set the state to IDLE and clear the bit buffer, bit_count, bytes_taken and coeff_idx.
REQ-030 SHALL have reset values in_ready=0, coeff_valid=0, coeff=0, coeff_idx=0, done=0 and err_range=0.
REQ-031 SHALL, if reset occurs mid-polynomial, discard all partial data; a new start is then required.

Structure
REQ-032 SHALL place Q, NUM_COEFFS and the FSM state enum in the shared package kyber_pkg.
REQ-033 SHALL place no sub-module inside the block; the bit accumulator stays inline in a single always_ff plus combinational outputs.

Verification
REQ-034 SHALL cover this scenario: ELL=12, start, bytes 49 8B 0B -> coeff0=2889 (idx 0) and coeff1=184 (idx 1), err_range=0.
REQ-035 SHALL cover this scenario: ELL=12, next bytes FF FE CE -> coeff2=3839 with err_range going to 1 and staying 1, then coeff3=3311.
REQ-036 SHALL cover this scenario: full 384 bytes with coeff_ready tied to 1 and in_valid tied to 1 -> 256 coefficients, done pulse on cycle 640 after start, and in_ready=0 thereafter.
REQ-037 SHALL cover this scenario: coeff_ready randomly low -> coeff and coeff_idx held stable while stalled, and no byte is lost or duplicated.
REQ-038 SHALL cover this scenario: ELL=1 with byte A5 -> coefficients 1,0,1,0,0,1,0,1.
REQ-039 SHALL cover this scenario: rst_n low after 100 bytes -> all outputs 0 immediately; a new start then decodes correctly from byte 0.
